// File: rtl/cache_nway_ctrl.sv
// N-way set-associative write-back/write-allocate cache with miss FSM.
// Optional stats counters: define CACHE_NWAY_STATS_EN.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req_*               CPU request (valid/ready, we, addr, wdata)
//   resp_*              one-cycle response (valid, hit, rdata)
//   mem_req_*, mem_we,  memory request (write-back or refill read)
//   mem_addr, mem_wdata
//   mem_resp_valid,     refill data return
//   mem_rdata
//   stat_*              hit/miss/write-back counters (CACHE_NWAY_STATS_EN)
module cache_nway_ctrl #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int WAYS        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            resp_valid,
    output logic                            resp_hit,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_we,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
`ifdef CACHE_NWAY_STATS_EN
    ,
    output logic [31:0]                     stat_hits,
    output logic [31:0]                     stat_misses,
    output logic [31:0]                     stat_wbs
`endif
);

    localparam int AW   = $clog2(WAYS);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int ADW  = TAG_WIDTH + INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        RF_REQ,
        RF_WAIT
    } state_t;

    state_t state, state_nx;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [AW-1:0]         age_q   [SETS][WAYS];
    logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

    logic                  r_we;
    logic [ADW-1:0]        r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [AW-1:0]         vic_q;

    logic [INDEX_WIDTH-1:0] r_idx;
    logic [TAG_WIDTH-1:0]   r_tag;

    assign r_idx = r_addr[INDEX_WIDTH-1:0];
    assign r_tag = r_addr[ADW-1:INDEX_WIDTH];

    logic          hit;
    logic [AW-1:0] hit_way;
    logic          inv_any;
    logic [AW-1:0] inv_way;
    logic [AW-1:0] lru_way;
    logic [AW-1:0] vic;
    logic [AW-1:0] acc_way;
    logic          upd;
    logic          fill;

    // Parallel tag compare across the set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[r_idx][w] && tag_q[r_idx][w] == r_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the oldest way.
    always_comb begin
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[r_idx][w]) begin
                inv_any = 1'b1;
                inv_way = AW'(w);
            end
            if (age_q[r_idx][w] == AW'(WAYS - 1)) begin
                lru_way = AW'(w);
            end
        end
        vic = inv_any ? inv_way : lru_way;
    end

    assign fill    = (state == RF_WAIT) && mem_resp_valid;
    assign upd     = ((state == LOOKUP) && hit) || fill;
    assign acc_way = (state == LOOKUP) ? hit_way : vic_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    resp_rdata = r_we ? r_wdata : data_q[r_idx][hit_way];
                    state_nx   = IDLE;
                end else if (valid_q[r_idx][vic] && dirty_q[r_idx][vic]) begin
                    state_nx = WB;
                end else begin
                    state_nx = RF_REQ;
                end
            end
            WB: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = {tag_q[r_idx][vic_q], r_idx};
                mem_wdata     = data_q[r_idx][vic_q];
                if (mem_req_ready) begin
                    state_nx = RF_REQ;
                end
            end
            RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = r_addr;
                if (mem_req_ready) begin
                    state_nx = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (mem_resp_valid) begin
                    resp_valid = 1'b1;
                    resp_rdata = r_we ? r_wdata : mem_rdata;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            vic_q   <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (state == LOOKUP && !hit) begin
                vic_q <= vic;
            end
        end
    end

    // Valid/dirty/age state; ages restart as a permutation 0..WAYS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AW'(w);
                end
            end
        end else begin
            if (state == LOOKUP && hit && r_we) begin
                dirty_q[r_idx][hit_way] <= 1'b1;
            end
            if (fill) begin
                valid_q[r_idx][vic_q] <= 1'b1;
                dirty_q[r_idx][vic_q] <= r_we;
            end
            if (upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == acc_way) begin
                        age_q[r_idx][w] <= '0;
                    end else if (age_q[r_idx][w] < age_q[r_idx][acc_way]) begin
                        age_q[r_idx][w] <= age_q[r_idx][w] + 1'b1;
                    end
                end
            end
        end
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && hit && r_we) begin
            data_q[r_idx][hit_way] <= r_wdata;
        end
        if (fill) begin
            tag_q[r_idx][vic_q]  <= r_tag;
            data_q[r_idx][vic_q] <= r_we ? r_wdata : mem_rdata;
        end
    end

`ifdef CACHE_NWAY_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (state == LOOKUP && hit && stat_hits != '1) begin
                stat_hits <= stat_hits + 1'b1;
            end
            if (state == LOOKUP && !hit && stat_misses != '1) begin
                stat_misses <= stat_misses + 1'b1;
            end
            if (state == WB && mem_req_ready && stat_wbs != '1) begin
                stat_wbs <= stat_wbs + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed self-checking bench for cache_nway_ctrl (default parameters).
// Stats counters are checked when CACHE_NWAY_STATS_EN is defined.
module tb_cache_nway_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef CACHE_NWAY_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
    logic [31:0] stat_wbs;
`endif

    cache_nway_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
`ifdef CACHE_NWAY_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses),
        .stat_wbs       (stat_wbs)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic        o_hit;
    logic [31:0] o_rdata;
    int          o_lat;
    int          o_nwb;
    logic [11:0] o_wb_addr;
    logic [31:0] o_wb_data;
    int          o_wb_cyc;
    int          o_nrf;
    logic [11:0] o_rf_addr;
    int          o_rf_cyc;
    logic        o_ready;

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one request and an always-ready memory; records what happened.
    task automatic xact(input logic we, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] md);
        logic done;
        logic rf_seen;
        o_hit = 1'bx;
        o_rdata = 'x;
        o_lat = 0;
        o_nwb = 0;
        o_nrf = 0;
        o_wb_addr = 'x;
        o_wb_data = 'x;
        o_rf_addr = 'x;
        o_wb_cyc = -1;
        o_rf_cyc = -1;
        done = 1'b0;
        rf_seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = wd;
        #1;
        o_ready = req_ready;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_resp_valid = rf_seen;
            mem_rdata = md;
            #1;
            if (resp_valid) begin
                o_hit = resp_hit;
                o_rdata = resp_rdata;
                o_lat = c;
                done = 1'b1;
            end else if (mem_req_valid) begin
                if (mem_we) begin
                    o_nwb++;
                    o_wb_addr = mem_addr;
                    o_wb_data = mem_wdata;
                    o_wb_cyc = c;
                end else begin
                    o_nrf++;
                    o_rf_addr = mem_addr;
                    o_rf_cyc = c;
                    rf_seen = 1'b1;
                end
            end
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({resp_valid, resp_hit, mem_req_valid, mem_we} !== 4'b0000)
            $display("FAIL reset_ctl got %b want 0000",
                     {resp_valid, resp_hit, mem_req_valid, mem_we});
        else passes++;
        checks++;
        if ({mem_addr, mem_wdata, resp_rdata} !== '0)
            $display("FAIL reset_data got %h/%h/%h want 0",
                     mem_addr, mem_wdata, resp_rdata);
        else passes++;
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL reset_ready got %b want 1", req_ready);
        else passes++;
    endtask

    task automatic test_cold();
        xact(1'b0, 12'h041, 32'h0, 32'hDEAD_BEEF);
        checks++;
        if (o_ready !== 1'b1)
            $display("FAIL cold_ready got %b want 1", o_ready);
        else passes++;
        checks++;
        if (o_nrf !== 1 || o_rf_addr !== 12'h041 || o_nwb !== 0)
            $display("FAIL cold_refill got n=%0d a=%h wb=%0d want 1/041/0",
                     o_nrf, o_rf_addr, o_nwb);
        else passes++;
        checks++;
        if (o_hit !== 1'b0 || o_rdata !== 32'hDEAD_BEEF)
            $display("FAIL cold_resp got %b/%h want 0/deadbeef",
                     o_hit, o_rdata);
        else passes++;
        xact(1'b0, 12'h041, 32'h0, 32'h0);
        checks++;
        if (o_hit !== 1'b1 || o_rdata !== 32'hDEAD_BEEF || o_lat !== 1)
            $display("FAIL warm_hit got %b/%h lat=%0d want 1/deadbeef/1",
                     o_hit, o_rdata, o_lat);
        else passes++;
        checks++;
        if (o_nrf !== 0 || o_nwb !== 0)
            $display("FAIL warm_nomem got rf=%0d wb=%0d want 0/0",
                     o_nrf, o_nwb);
        else passes++;
    endtask

    task automatic test_back_to_back();
        xact(1'b0, 12'h081, 32'h0, 32'h2222_2222);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 12'h041;
        @(negedge clk);
        req_addr = 12'h081;
        #1;
        checks++;
        if ({resp_valid, resp_hit} !== 2'b11 || resp_rdata !== 32'hDEAD_BEEF)
            $display("FAIL b2b_first got %b%b/%h want 11/deadbeef",
                     resp_valid, resp_hit, resp_rdata);
        else passes++;
        checks++;
        if (req_ready !== 1'b0)
            $display("FAIL b2b_ready_resp got %b want 0", req_ready);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid} !== 2'b10)
            $display("FAIL b2b_idle got %b want 10", {req_ready, resp_valid});
        else passes++;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if ({resp_valid, resp_hit} !== 2'b11 || resp_rdata !== 32'h2222_2222)
            $display("FAIL b2b_second got %b%b/%h want 11/22222222",
                     resp_valid, resp_hit, resp_rdata);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_lru();
        do_reset();
        for (int t = 1; t <= 4; t++)
            xact(1'b0, 12'((t << 6) | 5), 32'h0, 32'h1000 + t);
        xact(1'b0, 12'h045, 32'h0, 32'h0);
        checks++;
        if (o_hit !== 1'b1 || o_rdata !== 32'h1001)
            $display("FAIL lru_t1_hit got %b/%h want 1/1001", o_hit, o_rdata);
        else passes++;
        xact(1'b0, 12'h145, 32'h0, 32'h1005);
        checks++;
        if (o_hit !== 1'b0 || o_nwb !== 0 || o_rf_addr !== 12'h145)
            $display("FAIL lru_t5_miss got %b wb=%0d a=%h want 0/0/145",
                     o_hit, o_nwb, o_rf_addr);
        else passes++;
`ifdef CACHE_NWAY_STATS_EN
        checks++;
        if (stat_hits !== 32'd1 || stat_misses !== 32'd5 || stat_wbs !== 32'd0)
            $display("FAIL stats got %0d/%0d/%0d want 1/5/0",
                     stat_hits, stat_misses, stat_wbs);
        else passes++;
`endif
        xact(1'b0, 12'h045, 32'h0, 32'h0);
        checks++;
        if (o_hit !== 1'b1 || o_rdata !== 32'h1001)
            $display("FAIL lru_t1_again got %b/%h want 1/1001", o_hit, o_rdata);
        else passes++;
        xact(1'b0, 12'h085, 32'h0, 32'h2002);
        checks++;
        if (o_hit !== 1'b0 || o_nrf !== 1 || o_rdata !== 32'h2002)
            $display("FAIL lru_t2_evicted got %b rf=%0d d=%h want 0/1/2002",
                     o_hit, o_nrf, o_rdata);
        else passes++;
    endtask

    task automatic test_writeback();
        xact(1'b1, 12'h0C0, 32'h1234, 32'hAAAA_0003);
        checks++;
        if (o_hit !== 1'b0 || o_rdata !== 32'h1234 || o_rf_addr !== 12'h0C0)
            $display("FAIL wb_store got %b/%h a=%h want 0/1234/0c0",
                     o_hit, o_rdata, o_rf_addr);
        else passes++;
        for (int t = 4; t <= 6; t++)
            xact(1'b0, 12'(t << 6), 32'h0, 32'hAAAA_0000 + t);
        xact(1'b0, 12'h1C0, 32'h0, 32'hAAAA_0007);
        checks++;
        if (o_nwb !== 1 || o_wb_addr !== 12'h0C0 || o_wb_data !== 32'h1234)
            $display("FAIL wb_evict got n=%0d a=%h d=%h want 1/0c0/1234",
                     o_nwb, o_wb_addr, o_wb_data);
        else passes++;
        checks++;
        if (o_nrf !== 1 || o_rf_addr !== 12'h1C0 || o_wb_cyc >= o_rf_cyc)
            $display("FAIL wb_order got rf=%0d a=%h wbc=%0d rfc=%0d want 1/1c0/wb first",
                     o_nrf, o_rf_addr, o_wb_cyc, o_rf_cyc);
        else passes++;
        checks++;
        if (o_hit !== 1'b0 || o_rdata !== 32'hAAAA_0007)
            $display("FAIL wb_resp got %b/%h want 0/aaaa0007", o_hit, o_rdata);
        else passes++;
    endtask

    task automatic test_stall();
        xact(1'b1, 12'h082, 32'h5A5A_0001, 32'h0);
        xact(1'b0, 12'h0C2, 32'h0, 32'h3);
        xact(1'b0, 12'h102, 32'h0, 32'h4);
        xact(1'b0, 12'h142, 32'h0, 32'h5);
        @(negedge clk);
        mem_req_ready = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 12'h182;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({mem_req_valid, mem_we, mem_addr, mem_wdata, req_ready} !==
                {1'b1, 1'b1, 12'h082, 32'h5A5A_0001, 1'b0})
                $display("FAIL stall_wb_%0d got v%b w%b a=%h d=%h r%b want 1/1/082/5a5a0001/0",
                         i, mem_req_valid, mem_we, mem_addr, mem_wdata, req_ready);
            else passes++;
        end
        mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            #1;
            checks++;
            if ({mem_req_valid, mem_we, mem_addr, req_ready} !==
                {1'b1, 1'b0, 12'h182, 1'b0})
                $display("FAIL stall_rf_%0d got v%b w%b a=%h r%b want 1/0/182/0",
                         i, mem_req_valid, mem_we, mem_addr, req_ready);
            else passes++;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0006;
        #1;
        checks++;
        if ({resp_valid, resp_hit} !== 2'b10 || resp_rdata !== 32'h6)
            $display("FAIL stall_resp got %b%b/%h want 10/00000006",
                     resp_valid, resp_hit, resp_rdata);
        else passes++;
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 12'h203;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({mem_req_valid, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h203})
            $display("FAIL rstmid_rfreq got %b%b/%h want 10/203",
                     mem_req_valid, mem_we, mem_addr);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({resp_valid, mem_req_valid} !== 2'b00)
            $display("FAIL rstmid_in_rst got %b want 00", {resp_valid, mem_req_valid});
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (resp_valid !== 1'b0)
                $display("FAIL rstmid_late_%0d got %b want 0", i, resp_valid);
            else passes++;
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        xact(1'b0, 12'h203, 32'h0, 32'h0000_0203);
        checks++;
        if (o_hit !== 1'b0 || o_nrf !== 1 || o_rdata !== 32'h203)
            $display("FAIL rstmid_miss got %b rf=%0d d=%h want 0/1/00000203",
                     o_hit, o_nrf, o_rdata);
        else passes++;
        xact(1'b0, 12'h041, 32'h0, 32'h0000_0041);
        checks++;
        if (o_hit !== 1'b0 || o_rdata !== 32'h41)
            $display("FAIL rstmid_flushed got %b/%h want 0/00000041",
                     o_hit, o_rdata);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_cold();
        test_back_to_back();
        test_lru();
        test_writeback();
        test_stall();
        test_rst_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
